// File: rtl/step_mon_pkg.sv
// Shared constants and types for the step/dir pulse monitor.
package step_mon_pkg;

    // Register offsets, expressed as word index PADDR[4:2]
    localparam logic [2:0] OFF_POS1   = 3'd0;
    localparam logic [2:0] OFF_POS2   = 3'd1;
    localparam logic [2:0] OFF_STATUS = 3'd2;
    localparam logic [2:0] OFF_CTRL   = 3'd3;
    localparam logic [2:0] OFF_GLITCH = 3'd4;

    // STATUS bit positions
    localparam int STAT_GLITCH1  = 0;
    localparam int STAT_GLITCH2  = 1;
    localparam int STAT_DIR_ERR1 = 2;
    localparam int STAT_DIR_ERR2 = 3;
    localparam int STAT_BUSY1    = 4;
    localparam int STAT_BUSY2    = 5;

    // CTRL bit positions; bits 2..4 are write-only strobes
    localparam int CTRL_EN1       = 0;
    localparam int CTRL_EN2       = 1;
    localparam int CTRL_CLR_POS1  = 2;
    localparam int CTRL_CLR_POS2  = 3;
    localparam int CTRL_CLR_FLAGS = 4;

    // Per-axis pulse qualifier state
    typedef enum logic [1:0] {
        ST_LOW  = 2'd0,
        ST_PEND = 2'd1,
        ST_HIGH = 2'd2
    } axis_state_e;

endpackage

// File: rtl/step_axis_qual.sv
// One axis: synchronizes step/dir, qualifies step pulses by minimum high
// time, tracks signed position and records glitch / direction-setup errors.
module step_axis_qual
    import step_mon_pkg::*;
#(
    parameter int MIN_HIGH = 32,
    parameter int POS_W    = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    en_i,
    input  logic                    clr_pos_i,
    input  logic                    clr_flags_i,
    input  logic                    step_i,
    input  logic                    dir_i,
    output logic signed [POS_W-1:0] pos_o,
    output logic                    glitch_o,
    output logic                    dir_err_o,
    output logic                    busy_o,
    output logic [7:0]              glitch_cnt_o,
    output axis_state_e             state_o
);

    localparam logic [7:0] MIN_HIGH_C = 8'(MIN_HIGH);

    logic                    step_meta_q, step_s_q, dir_meta_q, dir_s_q;
    axis_state_e             state_q, state_d;
    logic [7:0]              hcnt_q, hcnt_d, hcnt_inc;
    logic                    dir_l_q, dir_l_d;
    logic signed [POS_W-1:0] pos_q, pos_d;
    logic                    glitch_q, glitch_d, dir_err_q, dir_err_d;
    logic [7:0]              gcnt_q, gcnt_d;
    logic                    step_ok, glitch_ev, dir_ev;

    // State, counters and the two-flop pin synchronizers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            step_meta_q <= 1'b0;
            step_s_q    <= 1'b0;
            dir_meta_q  <= 1'b0;
            dir_s_q     <= 1'b0;
            state_q     <= ST_LOW;
            hcnt_q      <= '0;
            dir_l_q     <= 1'b0;
            pos_q       <= '0;
            glitch_q    <= 1'b0;
            dir_err_q   <= 1'b0;
            gcnt_q      <= '0;
        end else begin
            step_meta_q <= step_i;
            step_s_q    <= step_meta_q;
            dir_meta_q  <= dir_i;
            dir_s_q     <= dir_meta_q;
            state_q     <= state_d;
            hcnt_q      <= hcnt_d;
            dir_l_q     <= dir_l_d;
            pos_q       <= pos_d;
            glitch_q    <= glitch_d;
            dir_err_q   <= dir_err_d;
            gcnt_q      <= gcnt_d;
        end
    end

    // Next-state: pulse qualification, then position and flag updates
    always_comb begin
        state_d   = state_q;
        hcnt_d    = hcnt_q;
        dir_l_d   = dir_l_q;
        pos_d     = pos_q;
        glitch_d  = glitch_q;
        dir_err_d = dir_err_q;
        gcnt_d    = gcnt_q;
        step_ok   = 1'b0;
        glitch_ev = 1'b0;
        dir_ev    = 1'b0;
        hcnt_inc  = hcnt_q + 8'd1;

        if (!en_i) begin
            // Disabled: abort any pulse silently
            state_d = ST_LOW;
            hcnt_d  = '0;
        end else begin
            case (state_q)
                ST_LOW: begin
                    if (step_s_q) begin
                        hcnt_d  = 8'd1;
                        dir_l_d = dir_s_q;
                        if (MIN_HIGH_C == 8'd1) begin
                            state_d = ST_HIGH;
                            step_ok = 1'b1;
                        end else begin
                            state_d = ST_PEND;
                        end
                    end
                end
                ST_PEND: begin
                    if (step_s_q) begin
                        hcnt_d = hcnt_inc;
                        if (hcnt_inc == MIN_HIGH_C) begin
                            state_d = ST_HIGH;
                            step_ok = 1'b1;
                        end
                    end else begin
                        state_d   = ST_LOW;
                        hcnt_d    = '0;
                        glitch_ev = 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (!step_s_q) begin
                        state_d = ST_LOW;
                    end
                end
                default: begin
                    state_d = ST_LOW;
                    hcnt_d  = '0;
                end
            endcase
            dir_ev = (state_q == ST_PEND || state_q == ST_HIGH) && (dir_s_q != dir_l_q);
        end

        // A clear on the qualifying edge discards that step
        if (clr_pos_i) begin
            pos_d = '0;
        end else if (step_ok) begin
            pos_d = dir_l_d ? (pos_q + POS_W'(1)) : (pos_q - POS_W'(1));
        end

        // Clear first, so an event on the same edge survives it
        if (clr_flags_i) begin
            glitch_d  = 1'b0;
            dir_err_d = 1'b0;
            gcnt_d    = '0;
        end
        if (glitch_ev) begin
            glitch_d = 1'b1;
            if (gcnt_d != 8'hFF) begin
                gcnt_d = gcnt_d + 8'd1;
            end
        end
        if (dir_ev) begin
            dir_err_d = 1'b1;
        end
    end

    assign pos_o        = pos_q;
    assign glitch_o     = glitch_q;
    assign dir_err_o    = dir_err_q;
    assign busy_o       = (state_q != ST_LOW);
    assign glitch_cnt_o = gcnt_q;
    assign state_o      = state_q;

endmodule

// File: rtl/step_pulse_monitor.sv
// APB3 slave wrapping two step/dir axis qualifiers.
// APB handshake: zero wait states, PREADY is always 1, so a write commits on
// the edge where PSEL & PENABLE & PWRITE are high; reads are combinational
// from PADDR[4:2] whenever PSEL & !PWRITE.
module step_pulse_monitor
    import step_mon_pkg::*;
#(
    parameter int MIN_HIGH = 32,
    parameter int POS_W    = 32
) (
    input  logic        PCLK,
    input  logic        PRESERN,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    input  logic        step1_in,
    input  logic        dir1_in,
    input  logic        step2_in,
    input  logic        dir2_in
);

    logic [2:0]              addr;
    logic                    ctrl_wr;
    logic [1:0]              en_q, en_d;
    logic                    clr_pos1, clr_pos2, clr_flags;
    logic signed [POS_W-1:0] pos1, pos2;
    logic                    glitch1, glitch2, dir_err1, dir_err2, busy1, busy2;
    logic [7:0]              gcnt1, gcnt2;
    axis_state_e             state1, state2;
    logic                    unused_bits;

    assign addr      = PADDR[4:2];
    assign ctrl_wr   = PSEL & PENABLE & PWRITE & (addr == OFF_CTRL);
    assign clr_pos1  = ctrl_wr & PWDATA[CTRL_CLR_POS1];
    assign clr_pos2  = ctrl_wr & PWDATA[CTRL_CLR_POS2];
    assign clr_flags = ctrl_wr & PWDATA[CTRL_CLR_FLAGS];
    assign en_d      = ctrl_wr ? PWDATA[CTRL_EN2:CTRL_EN1] : en_q;

    assign unused_bits = ^{PADDR[31:5], PADDR[1:0], PWDATA[31:5], state1, state2};

    // Enable register
    always_ff @(posedge PCLK) begin
        if (PRESERN) begin
            en_q <= 2'b00;
        end else begin
            en_q <= en_d;
        end
    end

    step_axis_qual #(.MIN_HIGH(MIN_HIGH), .POS_W(POS_W)) u_axis1 (
        .clk_i       (PCLK),
        .rst_i       (PRESERN),
        .en_i        (en_q[0]),
        .clr_pos_i   (clr_pos1),
        .clr_flags_i (clr_flags),
        .step_i      (step1_in),
        .dir_i       (dir1_in),
        .pos_o       (pos1),
        .glitch_o    (glitch1),
        .dir_err_o   (dir_err1),
        .busy_o      (busy1),
        .glitch_cnt_o(gcnt1),
        .state_o     (state1)
    );

    step_axis_qual #(.MIN_HIGH(MIN_HIGH), .POS_W(POS_W)) u_axis2 (
        .clk_i       (PCLK),
        .rst_i       (PRESERN),
        .en_i        (en_q[1]),
        .clr_pos_i   (clr_pos2),
        .clr_flags_i (clr_flags),
        .step_i      (step2_in),
        .dir_i       (dir2_in),
        .pos_o       (pos2),
        .glitch_o    (glitch2),
        .dir_err_o   (dir_err2),
        .busy_o      (busy2),
        .glitch_cnt_o(gcnt2),
        .state_o     (state2)
    );

    // Read mux; positions are sign-extended to the bus width
    always_comb begin
        PRDATA = '0;
        if (PSEL && !PWRITE && !PRESERN) begin
            case (addr)
                OFF_POS1:   PRDATA = 32'(pos1);
                OFF_POS2:   PRDATA = 32'(pos2);
                OFF_STATUS: PRDATA = {26'd0, busy2, busy1, dir_err2, dir_err1, glitch2, glitch1};
                OFF_CTRL:   PRDATA = {30'd0, en_q};
                OFF_GLITCH: PRDATA = {16'd0, gcnt2, gcnt1};
                default:    PRDATA = '0;
            endcase
        end
    end

    assign PREADY  = 1'b1;
    assign PSLVERR = 1'b0;

endmodule

// File: tb/tb_step_pulse_monitor.sv
// Directed bench for step_pulse_monitor: a MIN_HIGH=32 instance plus a
// MIN_HIGH=1 instance sharing the same bus and pins.
module tb_step_pulse_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] paddr = '0, pwdata = '0;
    logic [31:0] prdata, prdata2;
    logic        pready, pslverr, pready2, pslverr2;
    logic        step1 = 1'b0, dir1 = 1'b1, step2 = 1'b0, dir2 = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] rd1, rd2;

    // Clock and reset
    always #5 clk = ~clk;

    step_pulse_monitor #(.MIN_HIGH(32), .POS_W(32)) dut (
        .PCLK(clk), .PRESERN(rst), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr),
        .step1_in(step1), .dir1_in(dir1), .step2_in(step2), .dir2_in(dir2)
    );

    step_pulse_monitor #(.MIN_HIGH(1), .POS_W(32)) dut_mh1 (
        .PCLK(clk), .PRESERN(rst), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata2), .PREADY(pready2), .PSLVERR(pslverr2),
        .step1_in(step1), .dir1_in(dir1), .step2_in(step2), .dir2_in(dir2)
    );

    // Scoreboard check
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Driver tasks
    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = addr; pwdata = data;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] addr, output logic [31:0] d1, output logic [31:0] d2);
        @(negedge clk);
        psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = addr;
        #1;
        d1 = prdata;
        d2 = prdata2;
        @(negedge clk);
        psel = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] a, b;
        apb_read(addr, a, b);
        check(tag, a, exp);
    endtask

    task automatic pulse(input int axis, input int hi, input int lo);
        @(negedge clk);
        if (axis == 1) step1 = 1'b1; else step2 = 1'b1;
        repeat (hi) @(negedge clk);
        if (axis == 1) step1 = 1'b0; else step2 = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        rd_chk("rst_pos1", 32'h00, 32'h0);
        rd_chk("rst_pos2", 32'h04, 32'h0);
        rd_chk("rst_status", 32'h08, 32'h0);
        rd_chk("rst_ctrl", 32'h0C, 32'h0);
        rd_chk("rst_glitch", 32'h10, 32'h0);
        check("pready", {31'd0, pready}, 32'h1);

        // Five forward steps on axis 1
        apb_write(32'h0C, 32'h3);
        rd_chk("ctrl_en", 32'h0C, 32'h3);
        for (int i = 0; i < 5; i++) pulse(1, 150, 50);
        rd_chk("pos1_5", 32'h00, 32'd5);
        rd_chk("pos2_0", 32'h04, 32'h0);
        rd_chk("status_clean", 32'h08, 32'h0);
        rd_chk("glitch_clean", 32'h10, 32'h0);

        // Three reverse steps on axis 2
        for (int i = 0; i < 3; i++) pulse(2, 150, 50);
        rd_chk("pos2_m3", 32'h04, 32'hFFFF_FFFD);

        // clr_pos2 lands on the qualifying edge (34th edge after the rise)
        @(negedge clk);
        step2 = 1'b1;
        repeat (32) @(negedge clk);
        psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = 32'h0C; pwdata = 32'h0000_000B;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        repeat (114) @(negedge clk);
        step2 = 1'b0;
        repeat (50) @(negedge clk);
        rd_chk("pos2_clr_wins", 32'h04, 32'h0);
        rd_chk("pos1_kept", 32'h00, 32'd5);

        // Short pulse is a glitch
        pulse(1, 10, 50);
        rd_chk("glitch_pos1", 32'h00, 32'd5);
        rd_chk("glitch_status", 32'h08, 32'h1);
        rd_chk("glitch_cnt1", 32'h10, 32'h01);
        for (int i = 0; i < 300; i++) pulse(1, 10, 5);
        rd_chk("glitch_sat", 32'h10, 32'hFF);
        apb_write(32'h0C, 32'h13);
        rd_chk("clr_status", 32'h08, 32'h0);
        rd_chk("clr_glitch", 32'h10, 32'h0);
        rd_chk("ctrl_strobe_rd0", 32'h0C, 32'h3);

        // Direction changes 20 cycles into a 150-cycle pulse
        @(negedge clk);
        dir1 = 1'b1; step1 = 1'b1;
        repeat (20) @(negedge clk);
        dir1 = 1'b0;
        repeat (130) @(negedge clk);
        step1 = 1'b0;
        repeat (50) @(negedge clk);
        dir1 = 1'b1;
        repeat (5) @(negedge clk);
        rd_chk("dir_err_pos1", 32'h00, 32'd6);
        rd_chk("dir_err_status", 32'h08, 32'h4);

        // Axis 1 disabled: no counting, never busy
        apb_write(32'h0C, 32'h2);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            step1 = 1'b1;
            repeat (60) @(negedge clk);
            apb_read(32'h08, rd1, rd2);
            check("dis_status", rd1, 32'h4);
            repeat (88) @(negedge clk);
            step1 = 1'b0;
            repeat (50) @(negedge clk);
        end
        rd_chk("dis_pos1", 32'h00, 32'd6);

        // Reset in the middle of a pending pulse
        apb_write(32'h0C, 32'h3);
        @(negedge clk);
        step1 = 1'b1;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rd_chk("mid_rst_pos1", 32'h00, 32'h0);
        rd_chk("mid_rst_pos2", 32'h04, 32'h0);
        rd_chk("mid_rst_status", 32'h08, 32'h0);
        rd_chk("mid_rst_ctrl", 32'h0C, 32'h0);
        rd_chk("mid_rst_glitch", 32'h10, 32'h0);
        step1 = 1'b0;
        repeat (10) @(negedge clk);

        // MIN_HIGH=1: single-cycle pulse counts on the 3rd edge
        apb_write(32'h0C, 32'h1);
        @(negedge clk);
        psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = 32'h00;
        step1 = 1'b1;
        @(negedge clk);
        step1 = 1'b0;
        #1 check("mh1_edge1", prdata2, 32'h0);
        @(negedge clk);
        #1 check("mh1_edge2", prdata2, 32'h0);
        @(negedge clk);
        #1 check("mh1_edge3", prdata2, 32'h1);
        psel = 1'b0;
        repeat (10) @(negedge clk);
        apb_read(32'h08, rd1, rd2);
        check("mh32_short_glitch", rd1, 32'h1);
        check("mh1_no_glitch", rd2, 32'h0);

        // Unmapped offset
        apb_write(32'h14, 32'hFFFF_FFFF);
        apb_read(32'h14, rd1, rd2);
        check("unmapped_rd", rd1, 32'h0);
        check("pslverr", {31'd0, pslverr}, 32'h0);
        rd_chk("unmapped_wr_ignored", 32'h0C, 32'h1);

        // Final report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/step_pulse_monitor.md
Name: step_pulse_monitor

Overview:
- APB3 slave that receives the step/dir pin pairs for both plotter axes, either looped back from the stepper generator outputs or tapped at the driver connector.
- Qualifies each step pulse, tracks the signed position of each axis, and flags glitches and direction-setup violations.
- Firmware reads it to confirm that the commanded motion actually reached the pins.

Parameters:
- MIN_HIGH, 32: consecutive synchronized-high PCLK cycles that qualify a step pulse (legal range 1..255).
- POS_W, 32: width of the signed position counters (must be ≤ 32).

Ports:
- PCLK  in  1  clock.
- PRESERN  in  1  reset; synchronous, active-high (1 = reset).
- PSEL  in  1  APB peripheral select.
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  32  byte address; only PADDR[4:2] decoded.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data.
- PREADY  out  1  tied 1.
- PSLVERR  out  1  tied 0.
- step1_in  in  1  axis-1 step pin, asynchronous.
- dir1_in  in  1  axis-1 dir pin, asynchronous.
- step2_in  in  1  axis-2 step pin, asynchronous.
- dir2_in  in  1  axis-2 dir pin, asynchronous.

Behaviour:
- Synchronization: each pin passes through a 2-flop synchronizer (step_s, dir_s). All logic below uses only the synchronized signals.
- Per-axis FSM, states LOW, PEND, HIGH, with an 8-bit hcnt:
  - LOW: if en and step_s=1, go to PEND, set hcnt=1, latch dir_l=dir_s.
  - PEND, step_s=1: hcnt++. When hcnt==MIN_HIGH, apply pos += (dir_l ? +1 : −1) and go to HIGH.
  - PEND, step_s=0 before qualification: go to LOW, set the sticky glitch flag, increment glitch_cnt.
  - HIGH: go to LOW when step_s=0.
  - MIN_HIGH=1: qualification and the position update occur on the cycle that leaves LOW.
- Direction error: dir_s != dir_l while in PEND or HIGH sets the sticky dir_err flag. The step still counts with the latched dir_l.
- Latency: the position register updates on the edge where hcnt reaches MIN_HIGH, i.e. MIN_HIGH+2 edges after the pin is first sampled high.
- Position: POS_W-bit two's complement, wraps silently (0x7FFFFFFF + 1 → 0x80000000; 0 − 1 → 0xFFFFFFFF).
- glitch_cnt: 8 bits, saturates at 255.
- Enable: when en=0, the FSM is forced to LOW, hcnt=0, and no counts or flags change. Clearing en mid-pulse aborts the pulse with no glitch recorded.
- Reset: all synchronizer flops, FSMs (LOW), hcnt, pos, flags, glitch_cnt and en cleared to 0; PRDATA=0. Reset mid-pulse discards the pulse.
- APB write: occurs when PSEL & PWRITE & PENABLE, takes effect on that edge, zero wait states.
- APB read: PRDATA is combinational from PADDR[4:2] when PSEL & !PWRITE; 0 otherwise. Unmapped offsets read 0 and ignore writes.
- Register map (offset: content):
  - 0x00 POS1 (RO).
  - 0x04 POS2 (RO).
  - 0x08 STATUS (RO): bit0 glitch1, bit1 glitch2, bit2 dir_err1, bit3 dir_err2, bit4 busy1 (state≠LOW), bit5 busy2.
  - 0x0C CTRL (R/W): bit0 en1, bit1 en2. Write-only strobes, read as 0: bit2 clr_pos1, bit3 clr_pos2, bit4 clr_flags (clears flags and glitch counts).
  - 0x10 GLITCH (RO): [7:0] glitch_cnt1, [15:8] glitch_cnt2.
- Simultaneous events:
  - Clear and qualifying step on the same edge: clear wins and that step is discarded.
  - clr_flags and a new glitch/dir_err on the same edge: the flag ends set and the counter = 1.

Decomposition:
- Package step_mon_pkg holds:
  - register offset constants (POS1, POS2, STATUS, CTRL, GLITCH);
  - STATUS/CTRL bit-index constants;
  - the FSM state enum (LOW, PEND, HIGH).
- One sub-module, step_axis_qual, instantiated twice: synchronizer, FSM, hcnt, pos, flags, glitch_cnt, with en/clr inputs.
- Top level: APB decode and read mux.

Test Plan:
- Reset, write CTRL=0x3, then 5 axis-1 pulses (dir1=1, 150 cycles high, 50 low) -> POS1=5, POS2=0, STATUS=0, GLITCH=0.
- Axis-2, dir2=0, 3 valid pulses from POS2=0 -> POS2=0xFFFFFFFD. Then clr_pos2 on the same edge a qualifying pulse lands -> POS2=0.
- 10-cycle step1 pulse with MIN_HIGH=32 -> POS1 unchanged, glitch1=1, glitch_cnt1=1. Then 300 glitches -> glitch_cnt1=255. Then clr_flags -> STATUS=0, GLITCH=0.
- dir1 toggled 20 cycles into a 150-cycle pulse latched with dir1=1 -> POS1 +1, dir_err1=1.
- en1=0 with 4 pulses -> POS1 unchanged, busy1 never set. Assert PRESERN mid-PEND -> all registers 0 and FSM LOW on the next edge.
- MIN_HIGH=1, single 1-cycle pulse -> POS1 +1 exactly 3 edges after the pin rises. Read of offset 0x14 -> PRDATA=0, PSLVERR=0.
